// File: rtl/femto_bus_fabric.sv
// Address decoder, strobe steering and read-data mux between FemtoRV32 and NSLAVES peripherals.
// Optional bus timeout/abort logic is compiled in with `define FEMTO_BUS_TIMEOUT_EN.
module femto_bus_fabric #(
  parameter int                    NSLAVES       = 4,
  parameter logic [NSLAVES*16-1:0] SLAVE_BASE    = {16'h0001, 16'h0040, 16'h0001, 16'h0000},
  parameter int                    DEFAULT_SLAVE = 0,
  parameter int                    TIMEOUT       = 1023,
  parameter logic [31:0]           ERR_RDATA     = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             mem_addr,
  input  logic                    mem_rstrb,
  input  logic [3:0]              mem_wmask,
  output logic [31:0]             mem_rdata,
  output logic                    mem_rbusy,
  output logic                    mem_wbusy,
  output logic [NSLAVES-1:0]      s_rd,
  output logic [NSLAVES-1:0]      s_wr,
  input  logic [NSLAVES*32-1:0]   s_rdata,
  input  logic [NSLAVES-1:0]      s_rbusy,
  input  logic [NSLAVES-1:0]      s_wbusy,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [31:0]             err_addr
);
  // state   | meaning
  // IDLE    | no access outstanding, CPU strobes accepted
  // RD_WAIT | read issued to rsel, waiting for its rbusy to fall
  // WR_WAIT | write issued to wsel, waiting for its wbusy to fall
  // DRAIN   | access aborted, CPU released, waiting for the slave to finish
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DRAIN} state_t;

  localparam int             SW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [SW-1:0]  DEF_SEL = SW'(DEFAULT_SLAVE);

  state_t        state_q, state_d;
  logic [SW-1:0] dsel, rsel_q, rsel_d, wsel_q, wsel_d;
  logic          wr_req, rd_req, in_idle;
  logic          rd_busy_sel, wr_busy_sel, abort, drain_busy, err_rd;
  logic [31:0]   rdata_arr [NSLAVES];

  assign wr_req      = |mem_wmask;
  assign rd_req      = mem_rstrb & ~wr_req;
  assign in_idle     = (state_q == IDLE);
  assign rd_busy_sel = s_rbusy[rsel_q];
  assign wr_busy_sel = s_wbusy[wsel_q];

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    dsel = DEF_SEL;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (mem_addr[31:16] == SLAVE_BASE[16*i +: 16]) dsel = SW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NSLAVES; i++) rdata_arr[i] = s_rdata[32*i +: 32];
  end

`ifdef FEMTO_BUS_TIMEOUT_EN
  logic [9:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d, err_rd_q, err_rd_d, bus_err_q, bus_err_d;
  logic [31:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic        cnt_hit;

  assign cnt_hit    = (cnt_q + 10'd1) == 10'(TIMEOUT);
  assign abort      = cnt_hit & (((state_q == RD_WAIT) & rd_busy_sel) |
                                 ((state_q == WR_WAIT) & wr_busy_sel));
  assign drain_busy = op_wr_q ? wr_busy_sel : rd_busy_sel;

  always_comb begin
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    err_rd_d   = err_rd_q;
    bus_err_d  = bus_err_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    if (in_idle) begin
      cnt_d = '0;
      if (wr_req | mem_rstrb) begin
        addr_d  = mem_addr;
        op_wr_d = wr_req;
      end
      if (rd_req) err_rd_d = 1'b0;
    end else if ((state_q == RD_WAIT & rd_busy_sel) | (state_q == WR_WAIT & wr_busy_sel)) begin
      cnt_d = cnt_q + 10'd1;
    end
    if (abort & (state_q == RD_WAIT)) err_rd_d = 1'b1;
    if (err_clr) bus_err_d = 1'b0;
    // Set beats clear; only the first abort since the last clear records its address.
    if (abort) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) err_addr_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      err_rd_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_q     <= '0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      err_rd_q   <= err_rd_d;
      bus_err_q  <= bus_err_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_rd   = err_rd_q;
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_sink;

  assign abort       = 1'b0;
  assign drain_busy  = 1'b0;
  assign err_rd      = 1'b0;
  assign bus_err     = 1'b0;
  assign err_addr    = '0;
  assign unused_sink = ^{err_clr, mem_addr[15:0]};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rsel_q  <= DEF_SEL;
      wsel_q  <= DEF_SEL;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      wsel_q  <= wsel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    wsel_d  = wsel_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR_WAIT;
          wsel_d  = dsel;
        end else if (mem_rstrb) begin
          state_d = RD_WAIT;
          rsel_d  = dsel;
        end
      end
      RD_WAIT: begin
        if (!rd_busy_sel) state_d = IDLE;
        else if (abort)   state_d = DRAIN;
      end
      WR_WAIT: begin
        if (!wr_busy_sel) state_d = IDLE;
        else if (abort)   state_d = DRAIN;
      end
      DRAIN:   if (!drain_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_rd      = '0;
    s_wr      = '0;
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    mem_rdata = err_rd ? ERR_RDATA : rdata_arr[rsel_q];
    case (state_q)
      IDLE: begin
        if (resetn) begin
          s_rd[dsel] = rd_req;
          s_wr[dsel] = wr_req;
          mem_rbusy  = rd_req & s_rbusy[dsel];
          mem_wbusy  = wr_req & s_wbusy[dsel];
          if (rd_req) mem_rdata = rdata_arr[dsel];
        end
      end
      RD_WAIT: begin
        mem_rbusy = resetn & rd_busy_sel & ~abort;
        if (abort) mem_rdata = ERR_RDATA;
      end
      WR_WAIT: mem_wbusy = resetn & wr_busy_sel & ~abort;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_femto_bus_fabric.sv
// Directed bench for femto_bus_fabric: transaction-level model checked every cycle plus literal spot checks.
module tb_femto_bus_fabric;
  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef FEMTO_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn, mem_rstrb, mem_rbusy, mem_wbusy, err_clr, bus_err;
  logic [31:0]    mem_addr, mem_rdata, err_addr;
  logic [3:0]     mem_wmask, s_rd, s_wr, s_rbusy, s_wbusy;
  logic [NS*32-1:0] s_rdata;

  logic [15:0] bases [NS] = '{16'h0001, 16'h0040, 16'h0001, 16'h0000};

  int errors = 0;
  int checks = 0;
  bit started = 0;

  femto_bus_fabric #(
    .NSLAVES(NS), .SLAVE_BASE({16'h0000, 16'h0001, 16'h0040, 16'h0001}),
    .DEFAULT_SLAVE(0), .TIMEOUT(TO), .ERR_RDATA(ERRD)
  ) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .s_rd(s_rd), .s_wr(s_wr), .s_rdata(s_rdata),
    .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr), .bus_err(bus_err),
    .err_addr(err_addr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (a[31:16] == bases[i]) return i;
    return 0;
  endfunction

  // Model: kind 0 none / 1 read / 2 write in flight; drain after an abort.
  int          m_kind = 0, m_own_r = 0, m_own_w = 0, m_wait = 0, m_drain_kind = 0;
  bit          m_drain = 0, m_errdat = 0, m_berr = 0;
  logic [31:0] m_eaddr = '0, m_addr = '0;

  always @(negedge clk) begin : cmp
    logic [3:0]  e_srd, e_swr;
    logic        e_rb, e_wb;
    logic [31:0] e_rd;
    bit          chk_rd, fire, bsy, old_berr;
    int          d;
    if (started) begin
      e_srd = '0; e_swr = '0; e_rb = 0; e_wb = 0; chk_rd = 1; fire = 0; bsy = 0; d = 0;
      e_rd = m_errdat ? ERRD : s_rdata[32*m_own_r +: 32];
      if (!resetn) chk_rd = 0;
      else if (m_drain) begin
      end else if (m_kind == 0) begin
        d = decode(mem_addr);
        if (|mem_wmask) begin
          e_swr[d] = 1'b1; e_wb = s_wbusy[d];
        end else if (mem_rstrb) begin
          e_srd[d] = 1'b1; e_rb = s_rbusy[d]; chk_rd = 0;
        end
      end else begin
        bsy  = (m_kind == 1) ? s_rbusy[m_own_r] : s_wbusy[m_own_w];
        fire = TO_EN && bsy && (m_wait + 1 == TO);
        if (m_kind == 1) begin
          e_rb = bsy && !fire;
          if (fire) e_rd = ERRD;
        end else e_wb = bsy && !fire;
      end
      check("s_rd", 32'(s_rd), 32'(e_srd));
      check("s_wr", 32'(s_wr), 32'(e_swr));
      check("mem_rbusy", 32'(mem_rbusy), 32'(e_rb));
      check("mem_wbusy", 32'(mem_wbusy), 32'(e_wb));
      if (chk_rd) check("mem_rdata", mem_rdata, e_rd);
      check("bus_err", 32'(bus_err), 32'(m_berr));
      check("err_addr", err_addr, m_eaddr);

      if (!resetn) begin
        m_kind = 0; m_drain = 0; m_own_r = 0; m_own_w = 0; m_wait = 0;
        m_errdat = 0; m_berr = 0; m_eaddr = '0;
      end else begin
        old_berr = m_berr;
        if (m_drain) begin
          if (!((m_drain_kind == 1) ? s_rbusy[m_own_r] : s_wbusy[m_own_w])) m_drain = 0;
        end else if (m_kind == 0) begin
          if (|mem_wmask) begin
            m_kind = 2; m_own_w = d; m_wait = 0; m_addr = mem_addr;
          end else if (mem_rstrb) begin
            m_kind = 1; m_own_r = d; m_wait = 0; m_addr = mem_addr; m_errdat = 0;
          end
        end else if (!bsy) m_kind = 0;
        else begin
          m_wait++;
          if (fire) begin
            m_drain = 1; m_drain_kind = m_kind;
            if (m_kind == 1) m_errdat = 1;
            m_kind = 0;
          end
        end
        if (TO_EN && err_clr) m_berr = 0;
        if (fire) begin
          if (!old_berr) m_eaddr = m_addr;
          m_berr = 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 0; mem_addr = '0; mem_rstrb = 0; mem_wmask = '0; err_clr = 0;
    s_rbusy = '0; s_wbusy = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0A0A_0A0A};
    tick;
    started = 1;
    tick;
    @(negedge clk);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    tick; resetn = 1;

    // read to slave1 with 3 busy cycles, then address changes
    tick; mem_addr = 32'h0040_0004; mem_rstrb = 1; s_rbusy = 4'b0010;
    @(negedge clk);
    check("t1_s_rd", 32'(s_rd), 32'h2);
    check("t1_rbusy0", 32'(mem_rbusy), 32'h1);
    tick; mem_rstrb = 0;
    @(negedge clk); check("t1_rbusy1", 32'(mem_rbusy), 32'h1);
    tick;
    @(negedge clk); check("t1_rbusy2", 32'(mem_rbusy), 32'h1);
    tick; s_rbusy = '0;
    @(negedge clk);
    check("t1_rbusy3", 32'(mem_rbusy), 32'h0);
    check("t1_rdata", mem_rdata, 32'h1234_5678);
    tick; mem_addr = 32'h0;
    @(negedge clk); check("t1_hold", mem_rdata, 32'h1234_5678);

    // unmapped read falls to default slave
    tick; mem_addr = 32'h0077_0000; mem_rstrb = 1;
    @(negedge clk); check("t2_s_rd", 32'(s_rd), 32'h1);
    tick; mem_rstrb = 0;
    @(negedge clk); check("t2_rdata", mem_rdata, 32'h0A0A_0A0A);
    tick;

    // overlapping bases: lowest index wins, wbusy follows slave0 only
    tick; mem_addr = 32'h0001_0010; mem_wmask = 4'b0011; s_wbusy = 4'b0101;
    @(negedge clk);
    check("t3_s_wr", 32'(s_wr), 32'h1);
    check("t3_wbusy0", 32'(mem_wbusy), 32'h1);
    tick; mem_wmask = '0; s_wbusy = 4'b0100;
    @(negedge clk); check("t3_wbusy1", 32'(mem_wbusy), 32'h0);
    tick; s_wbusy = '0;
    tick;

    // slave3 read busy stuck high
    tick; mem_addr = 32'h0000_0100; mem_rstrb = 1; s_rbusy = 4'b1000;
    @(negedge clk); check("t4_s_rd", 32'(s_rd), 32'h8);
    tick; mem_rstrb = 0;
    repeat (7) tick;
    @(negedge clk);
    check("t4_rbusy_abort", 32'(mem_rbusy), TO_EN ? 32'h0 : 32'h1);
    check("t4_rdata_abort", mem_rdata, TO_EN ? ERRD : 32'h3333_3333);
    tick;
    @(negedge clk);
    check("t4_bus_err", 32'(bus_err), 32'(TO_EN));
    check("t4_err_addr", err_addr, TO_EN ? 32'h0000_0100 : 32'h0);
    tick; mem_addr = 32'h0001_0000; mem_rstrb = 1;
    @(negedge clk);
    check("t4_blocked_srd", 32'(s_rd), 32'h0);
    check("t4_blocked_rbusy", 32'(mem_rbusy), TO_EN ? 32'h0 : 32'h1);
    tick; mem_rstrb = 0; err_clr = 1;
    tick; err_clr = 0;
    @(negedge clk); check("t4_err_clr", 32'(bus_err), 32'h0);
    tick; s_rbusy = '0;
    tick;

    // reset in the middle of a read
    tick; mem_addr = 32'h0040_0000; mem_rstrb = 1; s_rbusy = 4'b0010;
    tick; mem_rstrb = 0;
    @(negedge clk); check("t5_rbusy_wait", 32'(mem_rbusy), 32'h1);
    tick; resetn = 0;
    @(negedge clk); check("t5_rbusy_rst", 32'(mem_rbusy), 32'h0);
    tick; resetn = 1;
    @(negedge clk);
    check("t5_rbusy_idle", 32'(mem_rbusy), 32'h0);
    check("t5_bus_err", 32'(bus_err), 32'h0);
    check("t5_err_addr", err_addr, 32'h0);
    tick; s_rbusy = '0; mem_addr = 32'h0040_0008; mem_rstrb = 1;
    @(negedge clk); check("t5_s_rd", 32'(s_rd), 32'h2);
    tick; mem_rstrb = 0;
    @(negedge clk); check("t5_rdata", mem_rdata, 32'h1234_5678);
    tick;

    // simultaneous read and write strobes: write wins
    tick; mem_addr = 32'h0040_0000; mem_rstrb = 1; mem_wmask = 4'b1111; s_wbusy = 4'b0010;
    @(negedge clk);
    check("t6_s_wr", 32'(s_wr), 32'h2);
    check("t6_s_rd", 32'(s_rd), 32'h0);
    check("t6_wbusy", 32'(mem_wbusy), 32'h1);
    tick; mem_rstrb = 0; mem_wmask = '0;
    @(negedge clk); check("t6_wr_wait", 32'(mem_wbusy), 32'h1);
    tick; s_wbusy = '0;
    tick;

    // write timeout with err_clr held through the abort: set wins
    tick; mem_addr = 32'h0000_0200; mem_wmask = 4'b0001; s_wbusy = 4'b1000; err_clr = 1;
    tick; mem_wmask = '0;
    repeat (7) tick;
    @(negedge clk); check("t7_wbusy_abort", 32'(mem_wbusy), TO_EN ? 32'h0 : 32'h1);
    tick; err_clr = 0;
    @(negedge clk);
    check("t7_bus_err", 32'(bus_err), 32'(TO_EN));
    check("t7_err_addr", err_addr, TO_EN ? 32'h0000_0200 : 32'h0);
    tick; s_wbusy = '0;
    tick;
    tick;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/femto_bus_fabric.md
Name: femto_bus_fabric

Overview:
- Parametrised successor to the fixed 7-way chip-select decoder and read mux in the femto SoC top.
- Sits between FemtoRV32 and NSLAVES memory-mapped peripherals (SPI flash, SPI RAM, UART, …).
- Decodes mem_addr[31:16] against a per-slave base table and steers rd/wr strobes.
- Holds the read-data mux on the slave that accepted the read until it completes, aggregates busy, and flags bus timeouts.

Parameters:
- NSLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, {16'h0001,16'h0040,16'h0001,16'h0000}, packed NSLAVES×16; slice i = upper address half matched by slave i.
- DEFAULT_SLAVE, 0, slave selected when no base matches (program flash).
- TIMEOUT, 1023, max wait cycles on busy before abort (10-bit counter, 1..1023).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout abort.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- mem_addr  in  32  CPU byte address
- mem_rstrb  in  1  CPU read strobe (one-cycle pulse)
- mem_wmask  in  4  CPU byte write mask; nonzero = write
- mem_rdata  out  32  read data to CPU
- mem_rbusy  out  1  read busy to CPU
- mem_wbusy  out  1  write busy to CPU
- s_rd  out  NSLAVES  per-slave read strobe
- s_wr  out  NSLAVES  per-slave write strobe
- s_rdata  in  NSLAVES×32  per-slave read data, slice i = slave i
- s_rbusy  in  NSLAVES  per-slave read busy
- s_wbusy  in  NSLAVES  per-slave write busy
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky timeout flag
- err_addr  out  32  mem_addr of the first aborted access

Behaviour:
- Decode (combinational):
  - hit[i] = (mem_addr[31:16] == SLAVE_BASE slice i).
  - Lowest index hit wins; no hit selects DEFAULT_SLAVE.
  - dsel = resulting index.
- Strobes (combinational, same cycle as the CPU strobe):
  - s_rd[dsel] = mem_rstrb, only when state==IDLE.
  - s_wr[dsel] = |mem_wmask, only when state==IDLE.
  - All other bits are 0.
  - If rstrb and wmask arrive together, the write wins and no s_rd is issued.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DRAIN.
  - IDLE:
    - on mem_rstrb: rsel<=dsel, cnt<=0, go to RD_WAIT.
    - on |mem_wmask: wsel<=dsel, cnt<=0, go to WR_WAIT.
  - RD_WAIT:
    - s_rbusy[rsel]==0 → IDLE.
    - else cnt++; cnt==TIMEOUT → DRAIN.
  - WR_WAIT: same as RD_WAIT, using s_wbusy[wsel].
  - DRAIN: slave busy is masked from the CPU; stay until that slave's busy falls, then → IDLE.
  - Minimum read/write occupancy: 1 cycle in *_WAIT even if the slave never asserts busy.
- mem_rbusy:
  - In the strobe cycle: s_rbusy[dsel].
  - In RD_WAIT: s_rbusy[rsel].
  - In DRAIN or IDLE: 0.
  - Forced to 0 in the cycle cnt reaches TIMEOUT.
- mem_wbusy: analogous, using s_wbusy and wsel.
- mem_rdata:
  - Equals s_rdata[rsel] in every state except IDLE-strobe cycle and abort. In IDLE after completion it keeps selecting rsel so data stays stable after the CPU changes address.
  - Equals ERR_RDATA from the abort cycle until the next rstrb.
- Timeout:
  - On abort: bus_err<=1 and err_addr<=address latched at strobe time, only if bus_err was 0 (first error is kept).
  - err_clr clears bus_err; err_addr is held.
  - err_clr coinciding with a new abort: the set wins.
- Reset (resetn==0 at a clk edge, including mid-transaction):
  - State←IDLE, rsel=wsel=DEFAULT_SLAVE, cnt=0, bus_err=0, err_addr=0.
  - The outstanding slave access is abandoned without DRAIN.
  - Outputs during reset: s_rd=s_wr=0, mem_rbusy=mem_wbusy=0.

Optional Feature:
- FEMTO_BUS_TIMEOUT_EN defined: timeout counter, DRAIN state, ERR_RDATA, bus_err and err_addr behave as above.
- Not defined:
  - Counter and DRAIN are removed; *_WAIT waits indefinitely for busy to fall.
  - bus_err and err_addr are tied to 0; err_clr is ignored.

Test Plan:
- NSLAVES=4, read at 0x0040_0004, slave1 busy 3 cycles, s_rdata1=0x12345678 → s_rd=0010 for one cycle, mem_rbusy high 3 cycles, mem_rdata=0x12345678; data held after mem_addr changes to 0x0000_0000.
- Read at unmapped 0x0077_0000 → s_rd=0001 (DEFAULT_SLAVE), data from slave0.
- Overlapping bases (slaves 0 and 2 both 16'h0001), write mask 4'b0011 at 0x0001_0010 → s_wr=0001 only; mem_wbusy follows s_wbusy[0].
- With FEMTO_BUS_TIMEOUT_EN, TIMEOUT=8, slave3 rbusy stuck high on read at 0x0000_0100:
  - after 8 cycles mem_rbusy=0, mem_rdata=0xDEADBEEF, bus_err=1, err_addr=0x0000_0100;
  - a new read to slave0 is blocked (mem_rbusy=0, no s_rd) until slave3 busy drops;
  - err_clr pulse clears bus_err.
- resetn low for 1 cycle while in RD_WAIT → next cycle IDLE, mem_rbusy=0, bus_err=0; a subsequent read completes normally.
- Simultaneous mem_rstrb=1 and mem_wmask=4'b1111 at 0x0040_0000 → s_wr=0010, s_rd=0000, FSM enters WR_WAIT.
